// File: rtl/conv_pkg.sv
// Shared convolution constants and helpers used by the conv engine and the
// feature-map collector.
package conv_pkg;

    localparam int IN_W     = 8;
    localparam int KERNEL_W = 8;
    localparam int KERNEL_K = 3;

    localparam int OUT_W = 20;
    localparam int PIX_W = 8;
    localparam int SHIFT = 4;
    localparam int MAP_H = 5;
    localparam int MAP_W = 5;

    // Linear raster index of a map element (row-major, x fastest).
    function automatic int map_idx(input int row, input int col, input int width = MAP_W);
        return row * width + col;
    endfunction

endpackage

// File: rtl/fmap_quant.sv
// Requantizes one signed conv result to pixel width: arithmetic shift,
// optional ReLU, then saturation to the signed pixel range.
module fmap_quant #(
    parameter int OUT_W = 20,
    parameter int PIX_W = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [OUT_W-1:0] in_data,
    input  logic                    relu_en,
    output logic signed [PIX_W-1:0] pix
);

    localparam logic signed [OUT_W-1:0] PIX_MAX = OUT_W'((1 <<< (PIX_W - 1)) - 1);
    localparam logic signed [OUT_W-1:0] PIX_MIN = OUT_W'(-(1 <<< (PIX_W - 1)));

    function automatic logic signed [PIX_W-1:0] saturate(input logic signed [OUT_W-1:0] v);
        logic signed [OUT_W-1:0] c;
        if (v > PIX_MAX)
            c = PIX_MAX;
        else if (v < PIX_MIN)
            c = PIX_MIN;
        else
            c = v;
        return c[PIX_W-1:0];
    endfunction

    logic signed [OUT_W-1:0] shifted;
    logic signed [OUT_W-1:0] rectified;

    always_comb begin
        shifted   = in_data >>> SHIFT;
        rectified = (relu_en && shifted < 0) ? '0 : shifted;
        pix       = saturate(rectified);
    end

endmodule

// File: rtl/fmap_collector.sv
// Collects requantized conv results into MAP_H x MAP_W feature maps using two
// ping-pong banks so the conv engine keeps streaming while a map is held.
module fmap_collector
    import conv_pkg::*;
#(
    parameter int OUT_W = conv_pkg::OUT_W,
    parameter int PIX_W = conv_pkg::PIX_W,
    parameter int SHIFT = conv_pkg::SHIFT,
    parameter int MAP_H = conv_pkg::MAP_H,
    parameter int MAP_W = conv_pkg::MAP_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [OUT_W-1:0]        in_data,
    input  logic                           relu_en,
    output logic                           map_valid,
    input  logic                           map_ready,
    output logic [MAP_H*MAP_W*PIX_W-1:0]   map_data,
    output logic [$clog2(MAP_W)-1:0]       col,
    output logic [$clog2(MAP_H)-1:0]       row
);

    localparam int MAP_BITS = MAP_H * MAP_W * PIX_W;
    localparam int CW       = $clog2(MAP_W);
    localparam int RW       = $clog2(MAP_H);
    localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - 1);

    logic [MAP_BITS-1:0]     bank [2];
    logic [1:0]              full;
    logic                    wb;
    logic                    rb;
    logic signed [PIX_W-1:0] pix;
    logic                    in_fire;
    logic                    out_fire;
    logic                    last_elem;

    fmap_quant #(
        .OUT_W (OUT_W),
        .PIX_W (PIX_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .in_data (in_data),
        .relu_en (relu_en),
        .pix     (pix)
    );

    // Handshake outputs come straight from registered flags, never from map_ready.
    assign in_ready  = !full[wb];
    assign map_valid = full[rb];
    assign map_data  = bank[rb];

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = map_valid && map_ready;
    assign last_elem = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            wb      <= 1'b0;
            rb      <= 1'b0;
            full    <= '0;
            bank[0] <= '0;
            bank[1] <= '0;
        end else begin
            // A fire on each side always targets different banks, so both
            // flag updates below can land in the same cycle.
            if (out_fire) begin
                full[rb] <= 1'b0;
                rb       <= !rb;
            end
            if (in_fire) begin
                bank[wb][map_idx(int'(row), int'(col), MAP_W) * PIX_W +: PIX_W] <= pix;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (last_elem) begin
                    full[wb] <= 1'b1;
                    wb       <= !wb;
                end
            end
        end
    end

endmodule

// File: tb/tb_fmap_collector.sv
// Randomized self-checking bench for fmap_collector against a queue-based
// model of held maps and the partial map being collected.
module tb_fmap_collector;

    localparam int OUT_W = 20;
    localparam int PIX_W = 8;
    localparam int SHIFT = 4;
    localparam int MAP_H = 5;
    localparam int MAP_W = 5;
    localparam int N     = MAP_H * MAP_W;
    localparam int MB    = N * PIX_W;
    localparam int CW    = $clog2(MAP_W);
    localparam int RW    = $clog2(MAP_H);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [OUT_W-1:0] in_data = '0;
    logic                    relu_en = 1'b0;
    logic                    map_valid;
    logic                    map_ready = 1'b0;
    logic [MB-1:0]           map_data;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;

    int checks = 0;
    int errors = 0;

    logic [MB-1:0] held_q[$];
    logic [MB-1:0] part = '0;
    int            part_n = 0;

    fmap_collector #(
        .OUT_W (OUT_W), .PIX_W (PIX_W), .SHIFT (SHIFT), .MAP_H (MAP_H), .MAP_W (MAP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .relu_en   (relu_en),
        .map_valid (map_valid),
        .map_ready (map_ready),
        .map_data  (map_data),
        .col       (col),
        .row       (row)
    );

    always #5 clk = ~clk;

    function automatic int ref_q(input int x, input bit relu);
        int s;
        s = x >>> SHIFT;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int rnd_data();
        if ($urandom_range(0, 3) == 0)
            return int'($urandom_range(0, 1048575)) - 524288;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic tick(input bit v, input int x, input bit relu, input bit mr);
        bit inf, outf;
        int p;
        in_valid  = v;
        in_data   = x[OUT_W-1:0];
        relu_en   = relu;
        map_ready = mr;
        inf  = v && (held_q.size() < 2);
        outf = mr && (held_q.size() > 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        map_ready = 1'b0;
        if (outf) void'(held_q.pop_front());
        if (inf) begin
            p = ref_q(x, relu);
            part[part_n*PIX_W +: PIX_W] = p[PIX_W-1:0];
            part_n++;
            if (part_n == N) begin
                held_q.push_back(part);
                part_n = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        map_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        held_q.delete();
        part_n = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL reset_map_valid: got %b exp 0", map_valid); end
        checks++; if (map_data !== '0) begin errors++; $display("FAIL reset_map_data: got %h exp 0", map_data); end
        checks++; if (row !== '0) begin errors++; $display("FAIL reset_row: got %0d exp 0", row); end
        checks++; if (col !== '0) begin errors++; $display("FAIL reset_col: got %0d exp 0", col); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < N; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b exp 1", i, in_ready); end
            tick(1'b1, i << 4, 1'b0, 1'b1);
        end
        checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL stream_valid: got %b exp 1", map_valid); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (map_data[i*PIX_W +: PIX_W] !== PIX_W'(i)) begin
                errors++; $display("FAIL stream_elem[%0d]: got %0d exp %0d", i, map_data[i*PIX_W +: PIX_W], i);
            end
        end
        checks++; if (row !== '0 || col !== '0) begin errors++; $display("FAIL stream_wrap: got row %0d col %0d exp 0 0", row, col); end
        tick(1'b0, 0, 1'b0, 1'b1);
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_drop: got %b exp 0", map_valid); end
    endtask

    task automatic test_quant();
        int  vals [4] = '{524287, -4096, -32, -32};
        bit  rl   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [PIX_W-1:0] exp_px [4] = '{8'h7F, 8'h80, 8'hFE, 8'h00};
        for (int i = 0; i < N; i++) begin
            if (i < 4) tick(1'b1, vals[i], rl[i], 1'b0);
            else       tick(1'b1, rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
        end
        checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL quant_valid: got %b exp 1", map_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (map_data[i*PIX_W +: PIX_W] !== exp_px[i]) begin
                errors++; $display("FAIL quant_elem[%0d]: got %h exp %h", i, map_data[i*PIX_W +: PIX_W], exp_px[i]);
            end
        end
        checks++; if (map_data !== held_q[0]) begin errors++; $display("FAIL quant_map: got %h exp %h", map_data, held_q[0]); end
        tick(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [MB-1:0] map1;
        for (int i = 0; i < 2 * N; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 1", i, in_ready); end
            tick(1'b1, rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
        end
        map1 = held_q[0];
        for (int k = 0; k < 3; k++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b exp 0", k, in_ready); end
            checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b exp 1", k, map_valid); end
            checks++; if (map_data !== map1) begin errors++; $display("FAIL bp_stall_data[%0d]: got %h exp %h", k, map_data, map1); end
            checks++; if (row !== '0 || col !== '0) begin errors++; $display("FAIL bp_stall_ctr[%0d]: got row %0d col %0d exp 0 0", k, row, col); end
            tick(1'b1, rnd_data(), 1'b0, 1'b0);
        end
        tick(1'b0, 0, 1'b0, 1'b1);
        checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL bp_map2_valid: got %b exp 1", map_valid); end
        checks++; if (map_data !== held_q[0]) begin errors++; $display("FAIL bp_map2_data: got %h exp %h", map_data, held_q[0]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b exp 1", in_ready); end
        tick(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 2 * N - 1; i++) tick(1'b1, rnd_data(), 1'b0, 1'b0);
        tick(1'b1, rnd_data(), 1'b0, 1'b1);
        checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b exp 1", map_valid); end
        checks++; if (map_data !== held_q[0]) begin errors++; $display("FAIL sim_data: got %h exp %h", map_data, held_q[0]); end
        checks++; if (row !== '0 || col !== '0) begin errors++; $display("FAIL sim_ctr: got row %0d col %0d exp 0 0", row, col); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %b exp 1", in_ready); end
        tick(1'b0, 0, 1'b0, 1'b1);
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL sim_drain: got %b exp 0", map_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < N + 12; i++) tick(1'b1, rnd_data(), 1'b0, 1'b0);
        do_reset();
        checks++; if (row !== '0 || col !== '0) begin errors++; $display("FAIL rmid_ctr: got row %0d col %0d exp 0 0", row, col); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b exp 0", map_valid); end
        checks++; if (map_data !== '0) begin errors++; $display("FAIL rmid_data: got %h exp 0", map_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b exp 1", in_ready); end
        for (int i = 0; i < N; i++) tick(1'b1, rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
        checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid: got %b exp 1", map_valid); end
        checks++; if (map_data !== held_q[0]) begin errors++; $display("FAIL rmid_new_data: got %h exp %h", map_data, held_q[0]); end
        tick(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int cyc = 0;
        int maps_done = 0;
        while (maps_done < 20 && cyc < 8000) begin
            bit v, mr;
            v  = ($urandom_range(0, 9) < 7);
            mr = ($urandom_range(0, 9) < 6);
            if (mr && held_q.size() > 0) maps_done++;
            tick(v, rnd_data(), 1'($urandom_range(0, 1)), mr);
            checks++; if (in_ready !== (held_q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %b exp %b", cyc, in_ready, held_q.size() < 2); end
            checks++; if (map_valid !== (held_q.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b exp %b", cyc, map_valid, held_q.size() > 0); end
            checks++; if (row !== RW'(part_n / MAP_W) || col !== CW'(part_n % MAP_W)) begin
                errors++; $display("FAIL rnd_ctr@%0d: got row %0d col %0d exp %0d %0d", cyc, row, col, part_n / MAP_W, part_n % MAP_W);
            end
            if (held_q.size() > 0) begin
                checks++; if (map_data !== held_q[0]) begin errors++; $display("FAIL rnd_map@%0d: got %h exp %h", cyc, map_data, held_q[0]); end
            end
            cyc++;
        end
        checks++; if (maps_done < 20) begin errors++; $display("FAIL rnd_timeout: got %0d maps exp 20", maps_done); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_quant();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
